// File: rtl/fsgnj_share_arbiter.sv
// Two-port round-robin arbiter in front of a shared FSGNJ/FSGNJN/FSGNJX stage.
// Optional NaN-boxed single-precision handling is enabled by defining FSGNJ_NANBOX_EN.
module fsgnj_share_arbiter #(
    parameter int unsigned BUS_WIDTH = 64,
    parameter int unsigned TAG_W     = 5,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [1:0]           req0_op,
    input  logic [BUS_WIDTH-1:0] req0_in1,
    input  logic [BUS_WIDTH-1:0] req0_in2,
    input  logic [TAG_W-1:0]     req0_tag,
`ifdef FSGNJ_NANBOX_EN
    input  logic                 req0_fmt,
`endif
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [1:0]           req1_op,
    input  logic [BUS_WIDTH-1:0] req1_in1,
    input  logic [BUS_WIDTH-1:0] req1_in2,
    input  logic [TAG_W-1:0]     req1_tag,
`ifdef FSGNJ_NANBOX_EN
    input  logic                 req1_fmt,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_src,
    output logic                 out_err,
    output logic [CNT_W-1:0]     cnt0,
    output logic [CNT_W-1:0]     cnt1
);

    localparam int unsigned MSB = BUS_WIDTH - 1;

    logic                 r_valid;
    logic [BUS_WIDTH-1:0] r_data;
    logic [TAG_W-1:0]     r_tag;
    logic                 r_src;
    logic                 r_err;
    logic                 r_ptr;
    logic [CNT_W-1:0]     r_cnt0;
    logic [CNT_W-1:0]     r_cnt1;

    logic                 w_adv;
    logic                 w_g0;
    logic                 w_g1;
    logic                 w_acc0;
    logic                 w_acc1;
    logic                 w_acc;
    logic [1:0]           w_op;
    logic [BUS_WIDTH-1:0] w_in1;
    logic [BUS_WIDTH-1:0] w_in2;
    logic [TAG_W-1:0]     w_tag;
    logic [BUS_WIDTH-1:0] w_res;

`ifdef FSGNJ_NANBOX_EN
    logic                 w_fmt;

    // fmt=1: unboxed operands become the canonical single NaN; sign lives in bit 31
    function automatic logic [BUS_WIDTH-1:0] f_inject(
        input logic [1:0]           op,
        input logic [BUS_WIDTH-1:0] a,
        input logic [BUS_WIDTH-1:0] b,
        input logic                 fmt
    );
        logic [BUS_WIDTH-1:0] a_b;
        logic [BUS_WIDTH-1:0] b_b;
        logic                 s;
        a_b = (&a[63:32]) ? a : 64'hFFFFFFFF_7FC00000;
        b_b = (&b[63:32]) ? b : 64'hFFFFFFFF_7FC00000;
        s   = 1'b0;
        f_inject = a;
        if (!fmt) begin
            case (op)
                2'b00:   f_inject = {b[MSB], a[MSB-1:0]};
                2'b01:   f_inject = {~b[MSB], a[MSB-1:0]};
                2'b10:   f_inject = {a[MSB] ^ b[MSB], a[MSB-1:0]};
                default: f_inject = a;
            endcase
        end else if (op != 2'b11) begin
            case (op)
                2'b00:   s = b_b[31];
                2'b01:   s = ~b_b[31];
                default: s = a_b[31] ^ b_b[31];
            endcase
            f_inject = {32'hFFFFFFFF, s, a_b[30:0]};
        end
    endfunction
`else
    function automatic logic [BUS_WIDTH-1:0] f_inject(
        input logic [1:0]           op,
        input logic [BUS_WIDTH-1:0] a,
        input logic [BUS_WIDTH-1:0] b
    );
        case (op)
            2'b00:   f_inject = {b[MSB], a[MSB-1:0]};
            2'b01:   f_inject = {~b[MSB], a[MSB-1:0]};
            2'b10:   f_inject = {a[MSB] ^ b[MSB], a[MSB-1:0]};
            default: f_inject = a;
        endcase
    endfunction
`endif

    // With no requester valid the pointer port is offered ready
    assign w_adv  = !r_valid || out_ready;
    assign w_g0   = req0_valid ? (!req1_valid || !r_ptr) : (!req1_valid && !r_ptr);
    assign w_g1   = !w_g0;
    assign w_acc0 = w_adv && w_g0 && req0_valid;
    assign w_acc1 = w_adv && w_g1 && req1_valid;
    assign w_acc  = w_acc0 || w_acc1;

    assign req0_ready = w_adv && w_g0;
    assign req1_ready = w_adv && w_g1;

    assign w_op  = w_g1 ? req1_op  : req0_op;
    assign w_in1 = w_g1 ? req1_in1 : req0_in1;
    assign w_in2 = w_g1 ? req1_in2 : req0_in2;
    assign w_tag = w_g1 ? req1_tag : req0_tag;
`ifdef FSGNJ_NANBOX_EN
    assign w_fmt = w_g1 ? req1_fmt : req0_fmt;
    assign w_res = f_inject(w_op, w_in1, w_in2, w_fmt);
`else
    assign w_res = f_inject(w_op, w_in1, w_in2);
`endif

    // Output register, round-robin pointer and saturating completion counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_tag   <= '0;
            r_src   <= 1'b0;
            r_err   <= 1'b0;
            r_ptr   <= 1'b0;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
        end else begin
            if (w_acc) begin
                r_valid <= 1'b1;
                r_data  <= w_res;
                r_tag   <= w_tag;
                r_src   <= w_acc1;
                r_err   <= (w_op == 2'b11);
                r_ptr   <= !w_acc1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            if (r_valid && out_ready && !r_src && !(&r_cnt0)) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (r_valid && out_ready && r_src && !(&r_cnt1)) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_tag   = r_tag;
    assign out_src   = r_src;
    assign out_err   = r_err;
    assign cnt0      = r_cnt0;
    assign cnt1      = r_cnt1;

endmodule

// File: tb/tb_fsgnj_share_arbiter.sv
// Directed plus randomized bench for fsgnj_share_arbiter against a cycle-level reference model.
// Counters are built 4 bits wide so saturation is reachable.
module tb_fsgnj_share_arbiter;

    localparam int unsigned BW   = 64;
    localparam int unsigned TW   = 5;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [1:0]    req0_op = '0, req1_op = '0;
    logic [BW-1:0] req0_in1 = '0, req0_in2 = '0, req1_in1 = '0, req1_in2 = '0;
    logic [TW-1:0] req0_tag = '0, req1_tag = '0;
    logic          req0_fmt = 1'b0, req1_fmt = 1'b0;
    logic          out_valid, out_src, out_err;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_data;
    logic [TW-1:0] out_tag;
    logic [CW-1:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            m_valid;
    logic [63:0]   m_data;
    int            m_tag, m_src, m_err, m_ptr, m_cnt0, m_cnt1;

    fsgnj_share_arbiter #(.BUS_WIDTH(BW), .TAG_W(TW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_tag(req0_tag),
`ifdef FSGNJ_NANBOX_EN
        .req0_fmt(req0_fmt),
`endif
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_tag(req1_tag),
`ifdef FSGNJ_NANBOX_EN
        .req1_fmt(req1_fmt),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_src(out_src), .out_err(out_err),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Result = sign * 2^63 + magnitude of in1, computed arithmetically
    function automatic logic [63:0] ref_inj(input int op, input logic [63:0] a,
                                            input logic [63:0] b, input bit fmt);
        logic [63:0] top, half, qnan, aa, bb, mag;
        int          sa, sb, s;
        top  = 64'h8000000000000000;
        half = 64'h0000000080000000;
        qnan = 64'hFFFFFFFF7FC00000;
        if (op == 3) return a;
        if (!fmt) begin
            sa = (a >= top) ? 1 : 0;
            sb = (b >= top) ? 1 : 0;
            mag = a % top;
        end else begin
            aa = (a >= 64'hFFFFFFFF00000000) ? a : qnan;
            bb = (b >= 64'hFFFFFFFF00000000) ? b : qnan;
            sa = ((aa % 64'h100000000) >= half) ? 1 : 0;
            sb = ((bb % 64'h100000000) >= half) ? 1 : 0;
            mag = aa % half;
        end
        s = (op == 0) ? sb : (op == 1) ? 1 - sb : (sa + sb) % 2;
        if (!fmt) return mag + (s != 0 ? top : 64'h0);
        return 64'hFFFFFFFF00000000 + (s != 0 ? half : 64'h0) + mag;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_tag = 0; m_src = 0; m_err = 0;
        m_ptr = 0; m_cnt0 = 0; m_cnt1 = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One clock: check everything at the falling edge, advance the model, move past the rising edge
    task automatic step();
        int  g, fmt;
        bit  adv, acc;
        @(negedge clk);
        if (req0_valid && req1_valid) g = m_ptr;
        else if (req0_valid)          g = 0;
        else if (req1_valid)          g = 1;
        else                          g = m_ptr;
        adv = !m_valid || out_ready;
        chk("req0_ready", 64'(req0_ready), 64'(adv && g == 0));
        chk("req1_ready", 64'(req1_ready), 64'(adv && g == 1));
        chk("out_valid",  64'(out_valid),  64'(m_valid));
        chk("out_data",   out_data,        m_data);
        chk("out_tag",    64'(out_tag),    64'(m_tag));
        chk("out_src",    64'(out_src),    64'(m_src));
        chk("out_err",    64'(out_err),    64'(m_err));
        chk("cnt0",       64'(cnt0),       64'(m_cnt0));
        chk("cnt1",       64'(cnt1),       64'(m_cnt1));
        if (m_valid && out_ready) begin
            if (m_src == 0 && m_cnt0 < CMAX) m_cnt0++;
            if (m_src == 1 && m_cnt1 < CMAX) m_cnt1++;
        end
        acc = adv && ((g == 0) ? req0_valid : req1_valid);
        if (acc) begin
`ifdef FSGNJ_NANBOX_EN
            fmt = (g == 0) ? int'(req0_fmt) : int'(req1_fmt);
`else
            fmt = 0;
`endif
            m_valid = 1;
            m_data  = (g == 0) ? ref_inj(int'(req0_op), req0_in1, req0_in2, fmt != 0)
                               : ref_inj(int'(req1_op), req1_in1, req1_in2, fmt != 0);
            m_tag   = (g == 0) ? int'(req0_tag) : int'(req1_tag);
            m_err   = ((g == 0 ? req0_op : req1_op) == 2'b11) ? 1 : 0;
            m_src   = g;
            m_ptr   = 1 - g;
        end else if (out_ready) begin
            m_valid = 0;
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] rnd_op();
        logic [63:0] v;
        v = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) v[63:32] = 32'hFFFFFFFF;
        return v;
    endfunction

    initial begin
        model_reset();
        do_reset();

        // Idle after reset
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_req0_ready", 64'(req0_ready), 64'd1);
        chk("rst_cnt0", 64'(cnt0), 64'd0);
        chk("rst_cnt1", 64'(cnt1), 64'd0);
        step();

        // Single FSGNJN on port 0
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b01; req0_tag = 5'd3;
        req0_in1 = 64'h3FF0000000000000; req0_in2 = 64'h4000000000000000;
        step();
        req0_valid = 1'b0;
        chk("t2_data", out_data, 64'hBFF0000000000000);
        chk("t2_tag", 64'(out_tag), 64'd3);
        chk("t2_src", 64'(out_src), 64'd0);
        step();
        chk("t2_cnt0", 64'(cnt0), 64'd1);

        // Full contention alternates grants
        do_reset();
        out_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t3_src", 64'(out_src), 64'(i % 2));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        chk("t3_cnt0", 64'(cnt0), 64'd3);
        chk("t3_cnt1", 64'(cnt1), 64'd3);

        // Back-pressure holds the output and blocks both ports
        do_reset();
        req1_valid = 1'b1; req1_op = 2'b10; req1_tag = 5'd9;
        req1_in1 = 64'hC000000000000000; req1_in2 = 64'h8000000000000000;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_data", out_data, 64'h4000000000000000);
            chk("t4_ready1", 64'(req1_ready), 64'd0);
            chk("t4_ready0", 64'(req0_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        req1_valid = 1'b0;
        step();

        // Illegal op passes in1 through with the error flag
        req0_valid = 1'b1; req0_op = 2'b11; req0_in1 = 64'h7FF8000000000000;
        req0_in2 = 64'h8000000000000000;
        step();
        req0_valid = 1'b0;
        chk("t5_data", out_data, 64'h7FF8000000000000);
        chk("t5_err", 64'(out_err), 64'd1);
        step();

`ifdef FSGNJ_NANBOX_EN
        req0_valid = 1'b1; req0_op = 2'b00; req0_fmt = 1'b1;
        req0_in1 = 64'h000000003F800000; req0_in2 = 64'hFFFFFFFFBF800000;
        step();
        req0_valid = 1'b0; req0_fmt = 1'b0;
        chk("t6_data", out_data, 64'hFFFFFFFFFFC00000);
        step();
`endif

        // Reset while a result is stalled discards it
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b00;
        step();
        req0_valid = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_cnt0", 64'(cnt0), 64'd0);
        do_reset();

        // Randomized traffic, long enough to saturate both counters
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            req0_op = 2'($urandom_range(0, 3)); req1_op = 2'($urandom_range(0, 3));
            req0_in1 = rnd_op(); req0_in2 = rnd_op();
            req1_in1 = rnd_op(); req1_in2 = rnd_op();
            req0_tag = 5'($urandom); req1_tag = 5'($urandom);
`ifdef FSGNJ_NANBOX_EN
            req0_fmt = 1'($urandom); req1_fmt = 1'($urandom);
`endif
            step();
        end
        chk("sat_cnt0", 64'(cnt0), 64'(CMAX));
        chk("sat_cnt1", 64'(cnt1), 64'(CMAX));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsgnj_share_arbiter.md
Name: fsgnj_share_arbiter

Overview:
- Shares one sign-injection datapath (FSGNJ/FSGNJN/FSGNJX) between two requesters: port 0 is the FP execute pipe, port 1 is the FP move/convert sequencer.
- Round-robin arbitration into a single registered output stage with valid/ready handshakes on both sides.
- Each result is returned with the requester's tag and a source ID, so the consumer can route it back.

Parameters:
- BUS_WIDTH, 64, operand/result width; legal values 64 or 32.
- TAG_W, 5, width of the requester tag (destination register index).
- CNT_W, 16, width of the per-port saturating completion counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  port-0 request valid
- req0_ready  out  1  port-0 request accepted this cycle
- req0_op  in  2  00=FSGNJ, 01=FSGNJN, 10=FSGNJX, 11=illegal
- req0_in1  in  BUS_WIDTH  magnitude source
- req0_in2  in  BUS_WIDTH  sign source
- req0_tag  in  TAG_W  tag returned with the result
- req1_valid, req1_ready, req1_op, req1_in1, req1_in2, req1_tag: same as port 0, for port 1
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  BUS_WIDTH  result
- out_tag  out  TAG_W  tag of the granted request
- out_src  out  1  0 = port 0, 1 = port 1
- out_err  out  1  op was 11 (illegal)
- cnt0  out  CNT_W  results delivered for port 0, saturating
- cnt1  out  CNT_W  results delivered for port 1, saturating

Behaviour:
- Reset (async assert, sync deassert at the consumer):
  - out_valid=0; out_data, out_tag, out_src, out_err=0; cnt0=cnt1=0.
  - Priority pointer = port 0 (port 0 wins the first contention).
- Stage enable: adv = !out_valid || out_ready. When adv=0, req0_ready = req1_ready = 0.
- Grant (combinational, registered result):
  - Only one valid request: that port is granted.
  - Both valid: the port indicated by the pointer is granted.
  - reqN_ready = adv && granted(N); at most one ready is high per cycle.
- Pointer update: only on an accepted transfer (reqN_valid && reqN_ready). The pointer then moves to the other port. Idle or stalled cycles leave it unchanged.
- Datapath, with S1 = in1[MSB] and S2 = in2[MSB]:
  - op 00: {S2, in1[BUS_WIDTH-2:0]}
  - op 01: {~S2, in1[BUS_WIDTH-2:0]}
  - op 10: {S1^S2, in1[BUS_WIDTH-2:0]}
  - op 11: out_data = in1 unchanged, out_err=1. Illegal ops are still arbitrated and counted normally.
  - No NaN special-casing; exponent and mantissa bits always pass straight from in1.
- Latency: exactly 1 cycle from acceptance to out_valid=1. Throughput is 1 per cycle while out_ready=1.
- Output stage:
  - Accepted request with adv=1: load data, tag, src, err; set out_valid=1.
  - No accept and out_ready=1: clear out_valid.
  - While out_valid && !out_ready: all out_* hold stable.
- Counters: cntN increments on the output handshake (out_valid && out_ready && out_src==N). Each holds at 2^CNT_W-1 once reached.
- Simultaneous drain and refill: the new result loads in the same cycle, and out_valid stays 1.
- Reset mid-transfer: the in-flight result is discarded; no counter increments.

Optional Feature:
- Macro: FSGNJ_NANBOX_EN. Meaningful only when BUS_WIDTH=64.
- With the macro: each request carries an extra input reqN_fmt (1 = single precision).
  - When fmt=1, any operand whose bits [63:32] are not all ones is replaced by 64'hFFFFFFFF_7FC00000 before injection.
  - Injection uses bit 31 as the sign.
  - The result is {32'hFFFFFFFF, sign, in1[30:0]}.
- Without the macro: no fmt port; all operations are full-width as specified above.

Test Plan:
- Reset then idle -> out_valid=0, req0_ready=1, cnt0=cnt1=0.
- Port 0, op=01, in1=0x3FF0000000000000, in2=0x4000000000000000, tag=3 -> next cycle out_data=0xBFF0000000000000, out_tag=3, out_src=0; cnt0=1 after out_ready.
- Both ports valid every cycle, out_ready=1, 6 cycles -> grants alternate 0,1,0,1,0,1; cnt0=cnt1=3.
- out_ready=0 for 4 cycles with port 1 holding op=10, in1=0xC000000000000000, in2=0x8000000000000000 -> out_data stays 0x4000000000000000 and both readies stay 0 until release.
- op=11, in1=0x7FF8000000000000 -> out_data=0x7FF8000000000000, out_err=1.
- FSGNJ_NANBOX_EN, fmt=1, in1=0x000000003F800000, in2=0xFFFFFFFFBF800000, op=00 -> out_data=0xFFFFFFFFFFC00000.
